// File: rtl/pseudo_spi_rx_intf.sv
// pseudo_spi_rx_intf: scan-chain receiver that shifts bytes in from SPI_SI and writes them to SRAM
//   CLK, RST         clock, asynchronous active-high reset
//   BGN              level start/abort/acknowledge from io_control
//   ADDR_BGN         first SRAM write address, latched at start
//   DATA_LEN         number of bytes to receive, latched at start
//   SPI_SI           serial data from the analog chip
//   SCLK1, SCLK2     non-overlapping two-phase scan clocks
//   SEL              parallel-capture select, high for the first bit slot only
//   CEN, D_WE, A, PO SRAM write port (CEN active-low)
//   spi_is_done      transfer complete, held until BGN drops
module pseudo_spi_rx_intf #(
    parameter int MEMORY_DATA_WIDTH = 8,
    parameter int MEMORY_ADDR_WIDTH = 9,
    parameter int RESERVED_DATA_LEN = 8,
    parameter int SCLK_DIV          = 1
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         BGN,
    input  logic [MEMORY_ADDR_WIDTH-1:0] ADDR_BGN,
    input  logic [RESERVED_DATA_LEN-1:0] DATA_LEN,
    input  logic                         SPI_SI,
    output logic                         SCLK1,
    output logic                         SCLK2,
    output logic                         SEL,
    output logic                         CEN,
    output logic                         D_WE,
    output logic [MEMORY_ADDR_WIDTH-1:0] A,
    output logic [MEMORY_DATA_WIDTH-1:0] PO,
    output logic                         spi_is_done
);
    localparam int DW = SCLK_DIV > 1 ? $clog2(SCLK_DIV) : 1;
    localparam int SW = MEMORY_DATA_WIDTH > 1 ? $clog2(MEMORY_DATA_WIDTH) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(SCLK_DIV - 1);
    localparam logic [SW-1:0] SL_MAX = SW'(MEMORY_DATA_WIDTH - 1);
    localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, SHIFT = 3'd2, WRITE = 3'd3, DONE = 3'd4;
    logic [2:0]                   state_q, state_d;
    logic [1:0]                   ph_q, ph_d;
    logic [DW-1:0]                div_q, div_d;
    logic [SW-1:0]                sl_q, sl_d;
    logic [MEMORY_ADDR_WIDTH-1:0] addr_q, addr_d, a_q, a_d;
    logic [RESERVED_DATA_LEN-1:0] cnt_q, cnt_d;
    logic [MEMORY_DATA_WIDTH-1:0] shreg_q, shreg_d, po_q, po_d;
    logic                         run, div_end, slot_end;
    assign run      = state_q == LOAD || state_q == SHIFT;
    assign div_end  = div_q == DIV_MAX;
    assign slot_end = div_end && ph_q == 2'd3;
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        a_d     = a_q;
        po_d    = po_q;
        sl_d    = sl_q;
        // Phase/divider counters only advance while scan clocks are running;
        // they sit at zero otherwise so every slot starts cleanly at P0.
        div_d   = run ? (div_end ? '0 : div_q + DW'(1)) : div_q;
        ph_d    = run && div_end ? ph_q + 2'd1 : ph_q;
        case (state_q)
            IDLE: if (BGN) begin
                addr_d  = ADDR_BGN;
                cnt_d   = DATA_LEN;
                ph_d    = '0;
                div_d   = '0;
                sl_d    = '0;
                state_d = DATA_LEN == '0 ? DONE : LOAD;
            end
            LOAD: state_d = slot_end ? SHIFT : LOAD;
            SHIFT: begin
                // Sample at the last CLK of P2, i.e. just before SCLK2 falls.
                if (div_end && ph_q == 2'd2)
                    shreg_d = MEMORY_DATA_WIDTH'({shreg_q, SPI_SI});
                if (slot_end) begin
                    sl_d = sl_q == SL_MAX ? '0 : sl_q + SW'(1);
                    if (sl_q == SL_MAX) begin
                        state_d = WRITE;
                        a_d     = addr_q;
                        po_d    = shreg_q;
                    end
                end
            end
            WRITE: begin
                addr_d  = addr_q + MEMORY_ADDR_WIDTH'(1);
                cnt_d   = cnt_q - RESERVED_DATA_LEN'(1);
                state_d = cnt_q == RESERVED_DATA_LEN'(1) ? DONE : SHIFT;
            end
            DONE: state_d = BGN ? DONE : IDLE;
            default: state_d = IDLE;
        endcase
        // Abort: the write strobe of a WRITE cycle is already on the bus, so only
        // the following cycle is forced back to idle outputs.
        if ((run || state_q == WRITE) && !BGN) begin
            state_d = IDLE;
            a_d     = '0;
            po_d    = '0;
        end
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            ph_q    <= '0;
            div_q   <= '0;
            sl_q    <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            shreg_q <= '0;
            a_q     <= '0;
            po_q    <= '0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            div_q   <= div_d;
            sl_q    <= sl_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            a_q     <= a_d;
            po_q    <= po_d;
        end
    end
    assign SCLK1       = run && ph_q == 2'd0;
    assign SCLK2       = run && ph_q == 2'd2;
    assign SEL         = state_q == LOAD;
    assign CEN         = state_q != WRITE;
    assign D_WE        = state_q == WRITE;
    assign A           = a_q;
    assign PO          = po_q;
    assign spi_is_done = state_q == DONE;
endmodule
